btb_fetch_ctrl: RTL

- Fetch-side controller wrapped around the branch target buffer. Owns the fetch PC register and drives the BTB lookup PC.
- Selects next PC in priority order: EX redirect, BTB prediction, PC+4.
- Carries each fetched instruction's prediction metadata through IF/ID and ID/EX shadow registers. Compares it against the EX-stage resolution.
- Generates the BTB update strobe, the mispredict flag, the pipeline flush and the redirect; keeps branch/mispredict statistics.

---
 rtl/btb_fetch_ctrl_pkg.sv | 25 ++
 rtl/btb_fetch_ctrl_meta_pipe.sv | 44 ++++
 rtl/btb_fetch_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/btb_fetch_ctrl_pkg.sv
// Shared types and constants for the BTB fetch controller: per-stage
// prediction metadata layout and the sequential PC increment.
package btb_fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    // 1 + 32 + 1 + 32 = 66 bits
    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } meta_t;

    localparam meta_t META_INVALID = '0;

    // Wrong direction, or right direction (taken) but wrong destination.
    function automatic logic is_mispredict(input meta_t m, input logic taken,
                                           input logic [31:0] target);
        return (taken != m.pred_taken) ||
               (taken && m.pred_taken && (target != m.pred_target));
    endfunction

endpackage

// File: rtl/btb_fetch_ctrl_meta_pipe.sv
// Two-stage shift register carrying prediction metadata from IF to EX,
// with kill (mispredict), hold (stall, bubbles ID/EX) and sync reset.
module pred_meta_pipe
    import btb_fetch_ctrl_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  kill_i,
    input  logic  hold_i,
    input  meta_t capture_i,
    output meta_t id_ex_o
);

    meta_t if_id_q, if_id_d;
    meta_t id_ex_q, id_ex_d;

    always_comb begin
        if_id_d = if_id_q;
        id_ex_d = id_ex_q;
        if (kill_i) begin
            // Kill wins over hold: both wrong-path slots are discarded.
            if_id_d = META_INVALID;
            id_ex_d = META_INVALID;
        end else if (hold_i) begin
            id_ex_d = META_INVALID;
        end else begin
            if_id_d = capture_i;
            id_ex_d = if_id_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_id_q <= META_INVALID;
            id_ex_q <= META_INVALID;
        end else begin
            if_id_q <= if_id_d;
            id_ex_q <= id_ex_d;
        end
    end

    assign id_ex_o = id_ex_q;

endmodule

// File: rtl/btb_fetch_ctrl.sv
// Fetch PC owner around the BTB: next-PC selection, EX-stage resolution of
// carried predictions, BTB update / redirect generation and statistics.
module btb_fetch_ctrl
    import btb_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [31:0]      btb_target,
    input  logic             btb_valid,
    input  logic             btb_taken,
    input  logic             ex_valid,
    input  logic             ex_is_cti,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic [31:0]      pc,
    output logic             flush,
    output logic             btb_update,
    output logic [31:0]      btb_update_pc,
    output logic [31:0]      btb_update_target,
    output logic             btb_mispredicted,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    meta_t       meta_ex;
    meta_t       capture;
    logic        pred_taken;
    logic        resolve;
    logic        mispred;
    logic [31:0] correct_pc;

    assign pred_taken = btb_valid & btb_taken;
    assign capture    = '{v: 1'b1, pc: pc_q, pred_taken: pred_taken, pred_target: btb_target};

    pred_meta_pipe u_meta_pipe (
        .clk_i     (clk),
        .rst_i     (rst),
        .kill_i    (mispred),
        .hold_i    (stall),
        .capture_i (capture),
        .id_ex_o   (meta_ex)
    );

    // Gated by rst so a resolution pending at reset neither updates nor flushes.
    assign resolve    = ~rst & ex_valid & ex_is_cti & meta_ex.v;
    assign mispred    = resolve & is_mispredict(meta_ex, ex_taken, ex_target);
    assign correct_pc = ex_taken ? ex_target : (meta_ex.pc + PC_INC);

    always_comb begin
        pc_d = pc_q + PC_INC;
        if (mispred) begin
            pc_d = correct_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = btb_target;
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve && !(&branch_cnt_q)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (mispred && !(&mispred_cnt_q)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            pc_q          <= pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign pc                = pc_q;
    assign flush             = mispred;
    assign btb_update        = resolve;
    assign btb_update_pc     = meta_ex.pc;
    assign btb_update_target = ex_target;
    assign btb_mispredicted  = mispred;
    assign branch_cnt        = branch_cnt_q;
    assign mispred_cnt       = mispred_cnt_q;

endmodule
